prog_ctr: RTL and testbench
===========================

// Module: prog_ctr
// PURPOSE
//  Program counter and branch unit. Consumes the ALU Zero flag and decoder branch
//  controls, and produces the instruction-fetch address each cycle. Uses a small
//  writable branch-target LUT indexed by a decoder field. Implements the
//  Start/Ack run handshake with the testbench/host.
// PARAMETERS
//  PCW         10  program counter / instruction address width
//  LUTW        4   branch LUT index width (2**LUTW entries of PCW bits)
//  START_ADDR  0   address loaded on reset and on Start
// PORTS
//  Clk       in   1     clock, all state updates on posedge
//  Reset     in   1     synchronous, active-low reset
//  Start     in   1     host request: (re)start program at START_ADDR
//  Halt      in   1     decoder: current instruction is halt
//  Jump      in   1     decoder: unconditional jump via LUT
//  BranchZ   in   1     decoder: branch via LUT if Zero==1
//  BranchNZ  in   1     decoder: branch via LUT if Zero==0
//  Zero      in   1     ALU zero flag for the current instruction (combinational)
//  LutIdx    in   LUTW  LUT index (branch target select / write address)
//  LutWe     in   1     LUT write enable (honoured in IDLE only)
//  LutWdata  in   PCW   LUT write data
//  ProgCtr   out  PCW   registered fetch address
//  Running   out  1     registered, 1 while state==RUN
//  Ack       out  1     registered, 1 while state==DONE
// BEHAVIOUR
//  - Reset==0 at posedge: state=IDLE, ProgCtr=START_ADDR, Running=0, Ack=0,
//    all LUT entries=0. Reset overrides every other input.
//  - States: IDLE, RUN, DONE. Running/Ack decode the state with no extra latency
//    (both are registered alongside the state).
//  - Start==1 in any state (Reset==1): next state=RUN, ProgCtr=START_ADDR, Ack=0.
//    The first instruction fetched is START_ADDR, in the first RUN cycle.
//  - IDLE, Start==0: hold ProgCtr. LutWe==1 writes LUT[LutIdx]=LutWdata.
//  - RUN, Start==0: next ProgCtr is chosen in priority order:
//      1. Halt     -> state=DONE, ProgCtr holds
//      2. Jump     -> ProgCtr=LUT[LutIdx]
//      3. (BranchZ & Zero) | (BranchNZ & ~Zero) -> ProgCtr=LUT[LutIdx]
//      4. otherwise ProgCtr=ProgCtr+1, modulo 2**PCW (0x3FF->0x000 at PCW=10)
//  - BranchZ and BranchNZ both asserted: branch is always taken.
//  - A branch whose condition fails falls through to +1.
//  - DONE, Start==0: ProgCtr holds and Ack=1.
//  - Halt/Jump/Branch are ignored in IDLE and DONE.
//  - LutWe is ignored outside IDLE.
//  - LUT read is combinational on LutIdx. Zero is sampled only at the posedge,
//    so there is 1-cycle latency from a flag to the new ProgCtr.
//  - Reset asserted mid-RUN: IDLE on the next edge, with the LUT cleared.
// TESTING
//  1. ProgCtr=0x05 in RUN, Reset=0 for 1 cycle -> ProgCtr=0, Running=0, Ack=0;
//     LUT[0..15] read back 0.
//  2. In IDLE write LUT[3]=0x040, then Start 1 cycle, then 5 plain cycles
//     -> ProgCtr 0,1,2,3,4,5 and Running=1.
//  3. At PC=5, LutIdx=3:
//     BranchZ with Zero=1 -> 0x040; BranchZ with Zero=0 -> 6;
//     BranchNZ with Zero=0 -> 0x040; BranchZ+BranchNZ -> 0x040.
//  4. Force PC=0x3FF via a LUT jump, then one plain cycle -> ProgCtr=0x000.
//  5. At PC=0x12 assert Halt and Jump together -> DONE, ProgCtr=0x12, Ack=1;
//     next Start -> ProgCtr=0, Ack=0, Running=1.
//  6. LutWe=1 with LutIdx=3, LutWdata=0x111 during RUN -> later jump to idx 3
//     still goes to 0x040 (write ignored).

Source files
------------

// File: rtl/prog_ctr.sv
// Program counter and branch unit with a writable branch-target LUT
// and a Start/Ack run handshake toward the host.
module prog_ctr #(
  parameter int unsigned PCW        = 10,
  parameter int unsigned LUTW       = 4,
  parameter logic [PCW-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic            Jump,
  input  logic            BranchZ,
  input  logic            BranchNZ,
  input  logic            Zero,
  input  logic [LUTW-1:0] LutIdx,
  input  logic            LutWe,
  input  logic [PCW-1:0]  LutWdata,
  output logic [PCW-1:0]  ProgCtr,
  output logic            Running,
  output logic            Ack
);

  localparam int unsigned NLUT = 1 << LUTW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [PCW-1:0] lut [NLUT];
  logic [PCW-1:0] target;
  logic           take;

  assign target = lut[LutIdx];
  assign take   = Jump
                | (BranchZ & Zero)
                | (BranchNZ & ~Zero);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      ProgCtr <= START_ADDR;
      Running <= 1'b0;
      Ack     <= 1'b0;
      for (int i = 0; i < NLUT; i++)
        lut[i] <= '0;
    end else if (Start) begin
      state   <= RUN;
      ProgCtr <= START_ADDR;
      Running <= 1'b1;
      Ack     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (LutWe)
            lut[LutIdx] <= LutWdata;
        end
        RUN: begin
          // Halt outranks any jump/branch on the same instruction
          if (Halt) begin
            state   <= DONE;
            Running <= 1'b0;
            Ack     <= 1'b1;
          end else if (take) begin
            ProgCtr <= target;
          end else begin
            ProgCtr <= ProgCtr + 1'b1;
          end
        end
        DONE: begin
          Ack <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          Running <= 1'b0;
          Ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_ctr.sv
// Directed self-checking bench for prog_ctr.
`timescale 1ns/1ps
module tb_prog_ctr;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Halt;
  logic       Jump;
  logic       BranchZ;
  logic       BranchNZ;
  logic       Zero;
  logic [3:0] LutIdx;
  logic       LutWe;
  logic [9:0] LutWdata;
  logic [9:0] ProgCtr;
  logic       Running;
  logic       Ack;

  int total = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  prog_ctr #(.PCW(10), .LUTW(4), .START_ADDR(10'd0)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Halt(Halt),
    .Jump(Jump),
    .BranchZ(BranchZ),
    .BranchNZ(BranchNZ),
    .Zero(Zero),
    .LutIdx(LutIdx),
    .LutWe(LutWe),
    .LutWdata(LutWdata),
    .ProgCtr(ProgCtr),
    .Running(Running),
    .Ack(Ack)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    Start = 0; Halt = 0; Jump = 0;
    BranchZ = 0; BranchNZ = 0; Zero = 0;
    LutWe = 0; LutWdata = '0;
  endtask

  task automatic jmp(input logic [3:0] idx);
    LutIdx = idx; Jump = 1;
    tick();
    Jump = 0;
  endtask

  initial begin
    clr();
    LutIdx = '0;
    Reset = 0;
    tick();
    Reset = 1;
    chk("rst_pc", ProgCtr, 0);
    chk("rst_run", Running, 0);
    chk("rst_ack", Ack, 0);

    // fill LUT with nonzero values so the reset clear is visible
    LutWe = 1;
    for (int i = 0; i < 16; i++) begin
      LutIdx = 4'(i);
      LutWdata = 10'(12'h100 + i);
      tick();
    end
    LutWe = 0;

    Start = 1; tick(); Start = 0;
    repeat (5) tick();
    chk("t1_pc5", ProgCtr, 5);
    Reset = 0; tick(); Reset = 1;
    chk("t1_pc", ProgCtr, 0);
    chk("t1_run", Running, 0);
    chk("t1_ack", Ack, 0);

    Start = 1; tick(); Start = 0;
    for (int i = 0; i < 16; i++) begin
      jmp(4'(i));
      chk($sformatf("t1_lut%0d", i), ProgCtr, 0);
    end

    Reset = 0; tick(); Reset = 1;
    LutWe = 1;
    LutIdx = 3; LutWdata = 10'h040; tick();
    LutIdx = 4; LutWdata = 10'h005; tick();
    LutIdx = 5; LutWdata = 10'h3FF; tick();
    LutIdx = 6; LutWdata = 10'h012; tick();
    LutWe = 0;

    jmp(4'd3);
    chk("idle_jmp_pc", ProgCtr, 0);
    chk("idle_run", Running, 0);

    Start = 1; tick(); Start = 0;
    chk("t2_pc0", ProgCtr, 0);
    chk("t2_run", Running, 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("t2_pc%0d", i), ProgCtr, i);
    end

    LutIdx = 3;
    BranchZ = 1; Zero = 1; tick(); clr();
    chk("t3_bz_taken", ProgCtr, 10'h040);
    jmp(4'd4);
    chk("t3_back5", ProgCtr, 5);
    LutIdx = 3;
    BranchZ = 1; Zero = 0; tick(); clr();
    chk("t3_bz_fall", ProgCtr, 6);
    jmp(4'd4);
    LutIdx = 3;
    BranchNZ = 1; Zero = 0; tick(); clr();
    chk("t3_bnz_taken", ProgCtr, 10'h040);
    jmp(4'd4);
    LutIdx = 3;
    BranchZ = 1; BranchNZ = 1; Zero = 1; tick(); clr();
    chk("t3_both", ProgCtr, 10'h040);
    BranchNZ = 1; Zero = 1; tick(); clr();
    chk("t3_bnz_fall", ProgCtr, 10'h041);

    jmp(4'd5);
    chk("t4_3ff", ProgCtr, 10'h3FF);
    tick();
    chk("t4_wrap", ProgCtr, 0);

    jmp(4'd6);
    chk("t5_pc12", ProgCtr, 10'h012);
    LutIdx = 3; Halt = 1; Jump = 1; tick(); clr();
    chk("t5_halt_pc", ProgCtr, 10'h012);
    chk("t5_ack", Ack, 1);
    chk("t5_run", Running, 0);
    Jump = 1; BranchZ = 1; Zero = 1; LutWe = 1;
    LutWdata = 10'h222; tick(); clr();
    chk("t5_done_hold", ProgCtr, 10'h012);
    chk("t5_done_ack", Ack, 1);
    Start = 1; tick(); Start = 0;
    chk("t5_restart_pc", ProgCtr, 0);
    chk("t5_restart_ack", Ack, 0);
    chk("t5_restart_run", Running, 1);

    LutIdx = 3; LutWe = 1; LutWdata = 10'h111; tick(); clr();
    chk("t6_pc1", ProgCtr, 1);
    jmp(4'd3);
    chk("t6_lut_kept", ProgCtr, 10'h040);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
